// File: rtl/conversion_sequencer.sv
// conversion_sequencer
// Dual-slope conversion controller: auto-zero, integrate, de-integrate,
// auto-ranging, 2^N sample averaging and a valid/ack result handshake.
//
// Ports:
//   clk_i, rst_i            clock, async active-low reset
//   start_i, mode_sel_i     start pulse (IDLE only); 00 single, 01 continuous, 1x hold
//   t_int_i, avg_log2_i     integrate length (0 -> 1), averaging exponent
//   autorange_en_i, range_i auto-range enable, initial/manual range
//   comp_i, sat_hi_i, sat_lo_i, ref_ok_i  sanitised AFE status
//   afe_sel_o, range_sel_o, afe_reset_o, ref_sign_o  AFE control
//   busy_o                  not IDLE
//   result_o, err_o, result_valid_o, overrun_o, result_ack_i  host side
module conversion_sequencer #(
    parameter int CNT_W        = 16,
    parameter int RANGES       = 5,
    parameter int RANGE_W      = 3,
    parameter int ZERO_CYC     = 64,
    parameter int AVG_MAX_LOG2 = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [1:0]         mode_sel_i,
    input  logic [CNT_W-1:0]   t_int_i,
    input  logic [1:0]         avg_log2_i,
    input  logic               autorange_en_i,
    input  logic [RANGE_W-1:0] range_i,
    input  logic               comp_i,
    input  logic               sat_hi_i,
    input  logic               sat_lo_i,
    input  logic               ref_ok_i,
    output logic [1:0]         afe_sel_o,
    output logic [RANGE_W-1:0] range_sel_o,
    output logic               afe_reset_o,
    output logic               ref_sign_o,
    output logic               busy_o,
    output logic [CNT_W:0]     result_o,
    output logic [1:0]         err_o,
    output logic               result_valid_o,
    output logic               overrun_o,
    input  logic               result_ack_i
);

    localparam int ACC_W = CNT_W + 1 + AVG_MAX_LOG2;
    localparam int NS_W  = AVG_MAX_LOG2 + 1;
    localparam logic [CNT_W-1:0] ZERO_LAST = CNT_W'(ZERO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_OVER  = 2'b01;
    localparam logic [1:0] ERR_REF   = 2'b10;
    localparam logic [1:0] ERR_TMOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_INTEG, S_DEINT, S_ACCUM, S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;          // shared phase counter
    logic [CNT_W-1:0]          t_int_q, t_int_d;
    logic [1:0]                avg_q, avg_d;
    logic [RANGE_W-1:0]        range_q, range_d;
    logic                      uprange_q, uprange_d;
    logic                      pol_q, pol_d;
    logic signed [CNT_W:0]     sample_q, sample_d;
    logic [CNT_W-1:0]          count_q, count_d;      // magnitude kept for the underrange test
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NS_W-1:0]           nsamp_q, nsamp_d;
    logic [1:0]                err_q, err_d;          // error pending for DONE
    logic [CNT_W:0]            result_q, result_d;
    logic [1:0]                err_out_q, err_out_d;
    logic                      valid_q, valid_d;
    logic                      overrun_q, overrun_d;

    logic [CNT_W-1:0]          deint_cnt;
    logic signed [CNT_W:0]     deint_mag;
    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   acc_shr;
    logic [NS_W-1:0]           nsamp_next;
    logic                      underrange;

    assign deint_cnt  = cnt_q + CNT_W'(1);
    assign deint_mag  = $signed({1'b0, deint_cnt});
    assign sample_ext = ACC_W'(sample_q);
    assign acc_shr    = acc_q >>> avg_q;
    assign nsamp_next = nsamp_q + NS_W'(1);
    // Only allowed to step down if this start never stepped up, so a signal
    // sitting near a range boundary cannot make the ranger oscillate.
    assign underrange = autorange_en_i && (range_q != '0) && !uprange_q &&
                        (count_q < (t_int_q >> 3));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        t_int_d   = t_int_q;
        avg_d     = avg_q;
        range_d   = range_q;
        uprange_d = uprange_q;
        pol_d     = pol_q;
        sample_d  = sample_q;
        count_d   = count_q;
        acc_d     = acc_q;
        nsamp_d   = nsamp_q;
        err_d     = err_q;
        result_d  = result_q;
        err_out_d = err_out_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (result_ack_i) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !mode_sel_i[1]) begin
                    t_int_d   = (t_int_i == '0) ? CNT_W'(1) : t_int_i;
                    avg_d     = (int'(avg_log2_i) > AVG_MAX_LOG2) ? 2'(AVG_MAX_LOG2) : avg_log2_i;
                    range_d   = (int'(range_i) >= RANGES) ? RANGE_W'(RANGES - 1) : range_i;
                    uprange_d = 1'b0;
                    acc_d     = '0;
                    nsamp_d   = '0;
                    err_d     = ERR_OK;
                    cnt_d     = '0;
                    state_d   = S_ZERO;
                end
            end
            S_ZERO: begin
                if (!ref_ok_i) begin
                    err_d   = ERR_REF;
                    state_d = S_DONE;
                end else if (cnt_q == ZERO_LAST) begin
                    cnt_d   = '0;
                    state_d = S_INTEG;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_INTEG: begin
                if (!ref_ok_i) begin
                    err_d   = ERR_REF;
                    state_d = S_DONE;
                end else if (sat_hi_i || sat_lo_i) begin
                    if (autorange_en_i && (int'(range_q) < RANGES - 1)) begin
                        range_d   = range_q + RANGE_W'(1);
                        uprange_d = 1'b1;
                        acc_d     = '0;
                        nsamp_d   = '0;
                        cnt_d     = '0;
                        state_d   = S_ZERO;
                    end else begin
                        err_d   = ERR_OVER;
                        state_d = S_DONE;
                    end
                end else if (cnt_q == t_int_q - CNT_W'(1)) begin
                    pol_d   = comp_i;
                    cnt_d   = '0;
                    state_d = S_DEINT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DEINT: begin
                // deint_cnt is the 1-based index of the current DEINT cycle
                if (!ref_ok_i) begin
                    err_d   = ERR_REF;
                    state_d = S_DONE;
                end else if (comp_i != pol_q) begin
                    count_d  = deint_cnt;
                    sample_d = pol_q ? deint_mag : -deint_mag;
                    state_d  = S_ACCUM;
                end else if (deint_cnt == CNT_MAX) begin
                    err_d   = ERR_TMOUT;
                    state_d = S_DONE;
                end else begin
                    cnt_d = deint_cnt;
                end
            end
            S_ACCUM: begin
                cnt_d = '0;
                if (!ref_ok_i) begin
                    err_d   = ERR_REF;
                    state_d = S_DONE;
                end else if (underrange) begin
                    range_d = range_q - RANGE_W'(1);
                    acc_d   = '0;
                    nsamp_d = '0;
                    state_d = S_ZERO;
                end else begin
                    acc_d   = acc_q + sample_ext;
                    nsamp_d = nsamp_next;
                    state_d = (nsamp_next == (NS_W'(1) << avg_q)) ? S_DONE : S_ZERO;
                end
            end
            S_DONE: begin
                result_d  = (err_q == ERR_OK) ? acc_shr[CNT_W:0] : '0;
                err_out_d = err_q;
                valid_d   = 1'b1;
                if (valid_q && !result_ack_i) overrun_d = 1'b1;
                err_d   = ERR_OK;
                acc_d   = '0;
                nsamp_d = '0;
                cnt_d   = '0;
                state_d = (mode_sel_i == 2'b01) ? S_ZERO : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            t_int_q   <= '0;
            avg_q     <= '0;
            range_q   <= '0;
            uprange_q <= 1'b0;
            pol_q     <= 1'b0;
            sample_q  <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            nsamp_q   <= '0;
            err_q     <= '0;
            result_q  <= '0;
            err_out_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_int_q   <= t_int_d;
            avg_q     <= avg_d;
            range_q   <= range_d;
            uprange_q <= uprange_d;
            pol_q     <= pol_d;
            sample_q  <= sample_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            nsamp_q   <= nsamp_d;
            err_q     <= err_d;
            result_q  <= result_d;
            err_out_q <= err_out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        afe_sel_o = 2'b00;
        if (state_q == S_INTEG) afe_sel_o = 2'b01;
        if (state_q == S_DEINT) afe_sel_o = 2'b10;
    end

    assign afe_reset_o    = (state_q == S_IDLE) || (state_q == S_ZERO);
    assign busy_o         = (state_q != S_IDLE);
    assign range_sel_o    = range_q;
    assign ref_sign_o     = pol_q;
    assign result_o       = result_q;
    assign err_o          = err_out_q;
    assign result_valid_o = valid_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_conversion_sequencer.sv
// Directed bench for conversion_sequencer (CNT_W=10, ZERO_CYC=4).
module tb_conversion_sequencer;

    localparam int CNT_W = 10;
    localparam int RANGE_W = 3;
    localparam int ZC = 4;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               start_i = 1'b0;
    logic [1:0]         mode_sel_i = 2'b00;
    logic [CNT_W-1:0]   t_int_i = '0;
    logic [1:0]         avg_log2_i = 2'b00;
    logic               autorange_en_i = 1'b0;
    logic [RANGE_W-1:0] range_i = '0;
    logic               comp_i = 1'b0;
    logic               sat_hi_i = 1'b0;
    logic               sat_lo_i = 1'b0;
    logic               ref_ok_i = 1'b1;
    logic               result_ack_i = 1'b0;
    logic [1:0]         afe_sel_o;
    logic [RANGE_W-1:0] range_sel_o;
    logic               afe_reset_o;
    logic               ref_sign_o;
    logic               busy_o;
    logic [CNT_W:0]     result_o;
    logic [1:0]         err_o;
    logic               result_valid_o;
    logic               overrun_o;

    conversion_sequencer #(
        .CNT_W(CNT_W), .RANGES(5), .RANGE_W(RANGE_W), .ZERO_CYC(ZC), .AVG_MAX_LOG2(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_sel_i(mode_sel_i),
        .t_int_i(t_int_i), .avg_log2_i(avg_log2_i), .autorange_en_i(autorange_en_i),
        .range_i(range_i), .comp_i(comp_i), .sat_hi_i(sat_hi_i), .sat_lo_i(sat_lo_i),
        .ref_ok_i(ref_ok_i), .afe_sel_o(afe_sel_o), .range_sel_o(range_sel_o),
        .afe_reset_o(afe_reset_o), .ref_sign_o(ref_sign_o), .busy_o(busy_o),
        .result_o(result_o), .err_o(err_o), .result_valid_o(result_valid_o),
        .overrun_o(overrun_o), .result_ack_i(result_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int zero_cnt = 0;
    int zero_base = 0;
    logic zero_prev = 1'b0;
    logic zero_now;

    assign zero_now = afe_reset_o && busy_o;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        zero_prev <= zero_now;
        if (zero_now && !zero_prev) zero_cnt <= zero_cnt + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_sel(input logic [1:0] s, input int budget);
        int n = 0;
        while (afe_sel_o !== s && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_afe_sel", afe_sel_o, s);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (result_valid_o !== 1'b1 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk("wait_valid", result_valid_o, 1);
    endtask

    task automatic start_pulse();
        @(negedge clk_i);
        start_i = 1'b1;
        t0 = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Hold comp at pol through INTEG, flip it in DEINT cycle k; returns in ACCUM.
    task automatic run_sample(input logic pol, input int k);
        comp_i = pol;
        wait_sel(2'b10, 3000);
        repeat (k - 1) @(negedge clk_i);
        comp_i = ~pol;
        @(negedge clk_i);
        comp_i = pol;
    endtask

    task automatic ack();
        result_ack_i = 1'b1;
        @(negedge clk_i);
        result_ack_i = 1'b0;
        chk("ack_clears_valid", result_valid_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_afe_reset", afe_reset_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_afe_sel", afe_sel_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_valid", result_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_range", range_sel_o, 0);
        chk("rst_ref_sign", ref_sign_o, 0);
        rst_i = 1'b1;

        // single, t_int=100, +50, latency
        t_int_i = 10'd100;
        start_pulse();
        run_sample(1'b1, 50);
        wait_valid(20);
        chk("t1_latency", cyc - t0, ZC + 153);
        chk("t1_result", $signed(result_o), 50);
        chk("t1_err", err_o, 0);
        chk("t1_idle", busy_o, 0);
        ack();

        // avg=2: 40 + 44 - 40 + 48 = 92 -> 23
        avg_log2_i = 2'd2;
        zero_base = zero_cnt;
        start_pulse();
        run_sample(1'b1, 40);
        run_sample(1'b1, 44);
        run_sample(1'b0, 40);
        run_sample(1'b1, 48);
        wait_valid(20);
        @(negedge clk_i);
        chk("avg_result", $signed(result_o), 23);
        chk("avg_zero_phases", zero_cnt - zero_base, 4);
        chk("avg_err", err_o, 0);
        ack();

        // uprange discards the accumulated sample: (20 + 22) / 2 = 21
        avg_log2_i = 2'd1;
        autorange_en_i = 1'b1;
        start_pulse();
        run_sample(1'b1, 30);
        wait_sel(2'b01, 100);
        sat_hi_i = 1'b1;
        @(negedge clk_i);
        sat_hi_i = 1'b0;
        chk("up_range", range_sel_o, 1);
        chk("up_restart_zero", afe_reset_o && busy_o, 1);
        run_sample(1'b1, 20);
        run_sample(1'b1, 22);
        wait_valid(20);
        chk("up_result", $signed(result_o), 21);
        chk("up_range_kept", range_sel_o, 1);
        ack();

        // range_i clamped to 4; saturation at top range is an overrange
        avg_log2_i = 2'd0;
        range_i = 3'd7;
        start_pulse();
        wait_sel(2'b01, 100);
        chk("clamp_range", range_sel_o, 4);
        sat_lo_i = 1'b1;
        @(negedge clk_i);
        sat_lo_i = 1'b0;
        wait_valid(20);
        chk("over_err", err_o, 1);
        chk("over_result", $signed(result_o), 0);
        ack();

        // underrange: t_int=800, count 50 < 100 at range 2 -> range 1, repeat
        t_int_i = 10'd800;
        range_i = 3'd2;
        start_pulse();
        run_sample(1'b1, 50);
        @(negedge clk_i);
        chk("down_range", range_sel_o, 1);
        run_sample(1'b1, 200);
        wait_valid(20);
        chk("down_result", $signed(result_o), 200);
        chk("down_range_final", range_sel_o, 1);
        ack();

        // uprange blocks a later downrange in the same start
        range_i = 3'd0;
        start_pulse();
        wait_sel(2'b01, 100);
        sat_hi_i = 1'b1;
        @(negedge clk_i);
        sat_hi_i = 1'b0;
        run_sample(1'b1, 50);
        wait_valid(20);
        chk("noflap_result", $signed(result_o), 50);
        chk("noflap_range", range_sel_o, 1);
        ack();

        // reference fault during DEINT
        autorange_en_i = 1'b0;
        t_int_i = 10'd100;
        comp_i = 1'b1;
        start_pulse();
        wait_sel(2'b10, 300);
        ref_ok_i = 1'b0;
        @(negedge clk_i);
        ref_ok_i = 1'b1;
        wait_valid(20);
        chk("ref_err", err_o, 2);
        chk("ref_result", $signed(result_o), 0);
        chk("ref_idle", busy_o, 0);
        ack();

        // comparator never flips -> timeout at count 1023
        t_int_i = 10'd10;
        comp_i = 1'b1;
        start_pulse();
        wait_valid(3000);
        chk("tmo_err", err_o, 3);
        chk("tmo_latency", cyc - t0, ZC + 10 + 1023 + 2);
        ack();

        // continuous, no ack -> overrun on the second result
        mode_sel_i = 2'b01;
        start_pulse();
        run_sample(1'b1, 5);
        wait_valid(20);
        chk("cont1_result", $signed(result_o), 5);
        chk("cont1_overrun", overrun_o, 0);
        run_sample(1'b1, 7);
        repeat (2) @(negedge clk_i);
        chk("cont2_result", $signed(result_o), 7);
        chk("cont2_overrun", overrun_o, 1);
        mode_sel_i = 2'b10;
        run_sample(1'b1, 9);
        repeat (2) @(negedge clk_i);
        chk("hold_result", $signed(result_o), 9);
        chk("hold_idle", busy_o, 0);
        start_pulse();
        chk("hold_start_ignored", busy_o, 0);
        chk("overrun_sticky", overrun_o, 1);
        ack();

        // reset clears overrun; ack coincident with DONE gives no overrun
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        chk("rst2_overrun", overrun_o, 0);
        mode_sel_i = 2'b01;
        start_pulse();
        run_sample(1'b1, 6);
        repeat (2) @(negedge clk_i);
        chk("co1_valid", result_valid_o, 1);
        run_sample(1'b1, 8);
        @(negedge clk_i);
        result_ack_i = 1'b1;
        @(negedge clk_i);
        result_ack_i = 1'b0;
        chk("co_valid", result_valid_o, 1);
        chk("co_result", $signed(result_o), 8);
        chk("co_overrun", overrun_o, 0);

        // asynchronous reset in the middle of INTEG
        wait_sel(2'b01, 100);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("areset_afe_reset", afe_reset_o, 1);
        chk("areset_busy", busy_o, 0);
        chk("areset_afe_sel", afe_sel_o, 0);
        chk("areset_valid", result_valid_o, 0);
        chk("areset_result", result_o, 0);
        mode_sel_i = 2'b00;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
